calc_ctrl: RTL

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_pkg.sv | 43 ++++
 rtl/calc_keymap.sv | 34 +++
 rtl/calc_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the keypad calculator.
package calc_pkg;

    localparam int BUF_LEN_DEF = 32;

    // ASCII codes used by the keypad and the entry buffer
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_CLR   = 8'h43;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_BS    = 8'h42;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == CH_PLUS) || (c == CH_MINUS) || (c == CH_MUL);
    endfunction

    // Unsigned modulo-2^32 arithmetic; the product keeps only its low word.
    function automatic logic [31:0] apply_op(input logic [31:0] a,
                                             input logic [7:0]  op,
                                             input logic [31:0] b);
        case (op)
            CH_PLUS:  return a + b;
            CH_MINUS: return a - b;
            CH_MUL:   return a * b;
            default:  return a;
        endcase
    endfunction

endpackage

// File: rtl/calc_keymap.sv
// Combinational cursor-position to key-character lookup for the 4x4 keypad.
module calc_keymap
    import calc_pkg::*;
(
    input  logic [1:0] i_x,
    input  logic [1:0] i_y,
    output logic [7:0] o_char
);

    // Row-major table: row 0 "123+", row 1 "456-", row 2 "789*", row 3 "C0=B"
    always_comb begin
        o_char = CH_SPACE;
        case ({i_y, i_x})
            4'd0:    o_char = "1";
            4'd1:    o_char = "2";
            4'd2:    o_char = "3";
            4'd3:    o_char = CH_PLUS;
            4'd4:    o_char = "4";
            4'd5:    o_char = "5";
            4'd6:    o_char = "6";
            4'd7:    o_char = CH_MINUS;
            4'd8:    o_char = "7";
            4'd9:    o_char = "8";
            4'd10:   o_char = "9";
            4'd11:   o_char = CH_MUL;
            4'd12:   o_char = CH_CLR;
            4'd13:   o_char = CH_0;
            4'd14:   o_char = CH_EQ;
            4'd15:   o_char = CH_BS;
            default: o_char = CH_SPACE;
        endcase
    end

endmodule

// File: rtl/calc_ctrl.sv
// Keypad calculator controller: cursor navigation, entry buffer editing and a
// one-character-per-cycle left-to-right evaluator.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int BUF_LEN = BUF_LEN_DEF
)(
    input  logic                 clk_in,
    input  logic                 sys_rst_n,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_sel,
    output logic [3:0]           cursor_x,
    output logic [3:0]           cursor_y,
    output logic [8*BUF_LEN-1:0] disp_str_flat,
    output logic [31:0]          result,
    output logic                 calc_done,
    output logic                 busy
);

    // len needs to reach BUF_LEN itself; buffer indices only reach BUF_LEN-1
    localparam int LW = $clog2(BUF_LEN + 1);
    localparam int IW = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(BUF_LEN);
    localparam logic [LW-1:0] LEN_ONE = LW'(1);
    localparam logic [LW-1:0] LEN_ZERO = '0;
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    logic [1:0]    r_cx;
    logic [1:0]    r_cy;
    logic [7:0]    r_buf [BUF_LEN];
    logic [LW-1:0] r_len;
    logic [31:0]   r_result;
    logic          r_done;
    logic          r_busy;
    state_t        r_state;
    logic [31:0]   r_acc;
    logic [31:0]   r_operand;
    logic [7:0]    r_pend;
    logic [IW-1:0] r_idx;

    logic [7:0]    w_key;
    logic [7:0]    w_eval_ch;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_bs_idx;
    logic [IW-1:0] w_last_idx;

    calc_keymap u_keymap (
        .i_x    (r_cx),
        .i_y    (r_cy),
        .o_char (w_key)
    );

    assign w_wr_idx   = r_len[IW-1:0];
    assign w_bs_idx   = IW'(r_len - LEN_ONE);
    assign w_last_idx = IW'(r_len - LEN_ONE);
    assign w_eval_ch  = r_buf[r_idx];

    assign cursor_x  = {2'b00, r_cx};
    assign cursor_y  = {2'b00, r_cy};
    assign result    = r_result;
    assign calc_done = r_done;
    assign busy      = r_busy;

    generate
        for (genvar gi = 0; gi < BUF_LEN; gi++) begin : g_flat
            assign disp_str_flat[8*gi +: 8] = r_buf[gi];
        end
    endgenerate

    // Cursor movement; a select in the same cycle wins and the move is dropped
    always_ff @(posedge clk_in) begin
        if (!sys_rst_n) begin
            r_cx <= 2'd0;
            r_cy <= 2'd0;
        end else if (btn_sel) begin
            r_cx <= r_cx;
        end else if (btn_up) begin
            r_cy <= r_cy - 2'd1;
        end else if (btn_down) begin
            r_cy <= r_cy + 2'd1;
        end else if (btn_left) begin
            r_cx <= r_cx - 2'd1;
        end else if (btn_right) begin
            r_cx <= r_cx + 2'd1;
        end
    end

    // Key handling in IDLE plus the evaluation FSM; selects are ignored while busy
    always_ff @(posedge clk_in) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < BUF_LEN; k++) r_buf[k] <= CH_SPACE;
            r_len     <= LEN_ZERO;
            r_result  <= 32'd0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
            r_acc     <= 32'd0;
            r_operand <= 32'd0;
            r_pend    <= CH_PLUS;
            r_idx     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (btn_sel) begin
                        if (is_digit(w_key) || is_op(w_key)) begin
                            if (r_done) begin
                                // A new entry after a result starts a fresh buffer
                                for (int k = 0; k < BUF_LEN; k++) r_buf[k] <= CH_SPACE;
                                r_buf[0] <= w_key;
                                r_len    <= LEN_ONE;
                                r_done   <= 1'b0;
                            end else if (r_len != LEN_MAX) begin
                                r_buf[w_wr_idx] <= w_key;
                                r_len           <= r_len + LEN_ONE;
                            end
                        end else if (w_key == CH_BS) begin
                            r_done <= 1'b0;
                            if (r_len != LEN_ZERO) begin
                                r_buf[w_bs_idx] <= CH_SPACE;
                                r_len           <= r_len - LEN_ONE;
                            end
                        end else if (w_key == CH_CLR) begin
                            for (int k = 0; k < BUF_LEN; k++) r_buf[k] <= CH_SPACE;
                            r_len    <= LEN_ZERO;
                            r_result <= 32'd0;
                            r_done   <= 1'b0;
                        end else if ((w_key == CH_EQ) && (r_len != LEN_ZERO)) begin
                            r_state   <= ST_EVAL;
                            r_busy    <= 1'b1;
                            r_acc     <= 32'd0;
                            r_operand <= 32'd0;
                            r_pend    <= CH_PLUS;
                            r_idx     <= '0;
                        end
                    end
                end
                ST_EVAL: begin
                    if (is_digit(w_eval_ch)) begin
                        r_operand <= r_operand * 32'd10 + {24'd0, w_eval_ch - CH_0};
                    end else if (is_op(w_eval_ch)) begin
                        r_acc     <= apply_op(r_acc, r_pend, r_operand);
                        r_pend    <= w_eval_ch;
                        r_operand <= 32'd0;
                    end
                    if (r_idx == w_last_idx) begin
                        r_state <= ST_FINAL;
                    end else begin
                        r_idx <= r_idx + IDX_ONE;
                    end
                end
                ST_FINAL: begin
                    // Fold in the trailing operand with the last pending operator
                    r_result <= apply_op(r_acc, r_pend, r_operand);
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
